// File: rtl/cordic_vector_clocked_if.sv
// Start/busy/done handshake and operand/result bus for the vectoring CORDIC engine.
// The requester drives master; the engine is the slave.
interface cordic_vector_clocked_if;
  logic        start;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic        busy;
  logic        done;
  logic [31:0] mag_out;
  logic [31:0] theta_out;

  modport master (
    output start, x_in, y_in,
    input  busy, done, mag_out, theta_out
  );

  modport slave (
    input  start, x_in, y_in,
    output busy, done, mag_out, theta_out
  );
endinterface

// File: rtl/cordic_vector_clocked.sv
// Iterative vectoring-mode CORDIC: (x, y) in Q2.30 -> magnitude and atan2 angle in Q3.29.
// One micro-rotation per clock after a quadrant pre-rotation covering the full circle.
module cordic_vector_clocked #(
  parameter int ITERS = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  cordic_vector_clocked_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ITER,
    S_SCALE,
    S_DONE
  } state_t;

  localparam logic signed [32:0] PI2       = 33'sh6487ED51;
  localparam logic signed [31:0] INV_GAIN  = 32'sh26DD3B6A;
  localparam logic        [4:0]  LAST_ITER = 5'(ITERS - 1);

  state_t             r_state;
  logic signed [33:0] r_x;
  logic signed [33:0] r_y;
  logic signed [32:0] r_z;
  logic        [4:0]  r_iter;
  logic               r_zero;
  logic               r_busy;
  logic               r_done;
  logic        [31:0] r_mag;
  logic        [31:0] r_theta;

  logic signed [33:0] w_xs;
  logic signed [33:0] w_ys;
  logic signed [32:0] w_atan;
  logic signed [65:0] w_prod;

  // atan(2^-i) in Q3.30; past the table the angle is indistinguishable from 2^-i.
  function automatic logic signed [32:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    return 33'sh3243F6A8;
      5'd1:    return 33'sh1DAC6705;
      5'd2:    return 33'sh0FADBAFD;
      5'd3:    return 33'sh07F56EA7;
      5'd4:    return 33'sh03FEAB77;
      5'd5:    return 33'sh01FFD55C;
      5'd6:    return 33'sh00FFFAAB;
      5'd7:    return 33'sh007FFF55;
      5'd8:    return 33'sh003FFFEB;
      5'd9:    return 33'sh001FFFFD;
      5'd10:   return 33'sh00100000;
      5'd11:   return 33'sh00080000;
      default: return 33'sh1 << (5'd30 - idx);
    endcase
  endfunction

  assign w_xs   = r_x >>> r_iter;
  assign w_ys   = r_y >>> r_iter;
  assign w_atan = atan_lut(r_iter);
  // Q2.30 x times Q2.30 gain; bits [62:31] are the Q3.29 magnitude.
  assign w_prod = 66'(r_x) * 66'(INV_GAIN);

  // NOTE: every register, datapath included, is cleared by rst so an aborted
  // operation leaves no stale operand or result behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_iter  <= '0;
      r_zero  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_mag   <= '0;
      r_theta <= '0;
    end else begin
      // NOTE: non-blocking updates let each micro-rotation read the pre-update x and y.
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x     <= {{2{bus.x_in[31]}}, bus.x_in};
            r_y     <= {{2{bus.y_in[31]}}, bus.y_in};
            r_busy  <= 1'b1;
            r_state <= S_PRE;
          end
        end
        S_PRE: begin
          r_zero <= (r_x == '0) && (r_y == '0);
          r_iter <= '0;
          if (!r_x[33]) begin
            r_z <= '0;
          end else if (!r_y[33]) begin
            r_x <= r_y;
            r_y <= -r_x;
            r_z <= PI2;
          end else begin
            r_x <= -r_y;
            r_y <= r_x;
            r_z <= -PI2;
          end
          r_state <= S_ITER;
        end
        S_ITER: begin
          if (!r_y[33]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          r_iter <= r_iter + 5'd1;
          if (r_iter == LAST_ITER) r_state <= S_SCALE;
        end
        S_SCALE: begin
          if (r_zero) begin
            r_mag   <= '0;
            r_theta <= '0;
          end else begin
            r_mag   <= w_prod[62:31];
            r_theta <= r_z[32:1];
          end
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.mag_out   = r_mag;
  assign bus.theta_out = r_theta;

endmodule

// File: tb/tb_cordic_vector_clocked.sv
// Scoreboard bench for cordic_vector_clocked against a real-valued atan2/hypot model.
module tb_cordic_vector_clocked;

  localparam longint TOL = 64'sd131072;

  typedef struct {
    string  tag;
    longint mag;
    longint theta;
    longint tol;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;
  exp_t sb[$];

  cordic_vector_clocked_if bus ();

  cordic_vector_clocked #(.ITERS(15)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    d = got - exp;
    n_tests++;
    if (d > tol || d < -tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/- %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input string tag);
    exp_t e;
    real rx, ry;
    rx = $itor($signed(x)) / 1073741824.0;
    ry = $itor($signed(y)) / 1073741824.0;
    e.tag = tag;
    if (x == 32'd0 && y == 32'd0) begin
      e.mag   = 0;
      e.theta = 0;
      e.tol   = 0;
    end else begin
      e.mag   = longint'($sqrt(rx * rx + ry * ry) * 536870912.0);
      e.theta = longint'($atan2(ry, rx) * 536870912.0);
      e.tol   = TOL;
    end
    return e;
  endfunction

  // Scoreboard consumer: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_mag"},   longint'($signed(bus.mag_out)),   e.mag,   e.tol);
        check({e.tag, "_theta"}, longint'($signed(bus.theta_out)), e.theta, e.tol);
      end
    end
  end

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input string tag, input bit push);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = x;
    bus.y_in  = y;
    if (push) sb.push_back(model(x, y, tag));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.done) check({tag, "_timeout"}, lat, 17, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string tag, output int lat);
    start_op(x, y, tag, 1'b1);
    wait_done(tag, lat);
  endtask

  initial begin
    int lat;
    int done_before;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  bus.busy, 0, 0);
    check("rst_done",  bus.done, 0, 0);
    check("rst_mag",   bus.mag_out, 0, 0);
    check("rst_theta", bus.theta_out, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Axis and diagonal cases
    start_op(32'h40000000, 32'h00000000, "x_axis", 1'b1);
    check("accept_busy", bus.busy, 1, 0);
    wait_done("x_axis", lat);
    check("latency", lat, 17, 0);
    check("busy_after", bus.busy, 0, 0);
    run_op(32'h00000000, 32'h40000000, "y_axis", lat);
    run_op(32'hC0000000, 32'h00000000, "neg_x", lat);
    check("neg_x_pos_pi", longint'(bus.theta_out[31]), 0, 0);
    run_op(32'h2D413CCD, 32'h2D413CCD, "diag_q1", lat);
    run_op(32'hE0000000, 32'hE0000000, "diag_q3", lat);
    run_op(32'h00000000, 32'hC0000000, "neg_y", lat);
    run_op(32'h80000000, 32'h80000000, "min_min", lat);
    run_op(32'h80000000, 32'h00000000, "min_x", lat);
    run_op(32'h00000000, 32'h00000000, "zero", lat);

    // Start re-pulsed while busy must be ignored
    done_before = n_done;
    start_op(32'h40000000, 32'h20000000, "repulse", 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x_in  = 32'h11111111;
    bus.y_in  = 32'hA5A5A5A5;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("repulse_busy", bus.busy, 1, 0);
    wait_done("repulse", lat);
    repeat (25) @(posedge clk);
    #1;
    check("repulse_one_done", n_done - done_before, 1, 0);

    // Reset mid-iteration aborts and clears everything
    done_before = n_done;
    start_op(32'h30000000, 32'h10000000, "abort", 1'b0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy",  bus.busy, 0, 0);
    check("abort_done",  bus.done, 0, 0);
    check("abort_mag",   bus.mag_out, 0, 0);
    check("abort_theta", bus.theta_out, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", n_done - done_before, 0, 0);
    run_op(32'h30000000, 32'h10000000, "post_rst", lat);
    check("post_rst_latency", lat, 17, 0);

    // Random sweep
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom(), $urandom(), "rand", lat);
    end

    repeat (5) @(posedge clk);
    check("sb_empty", sb.size(), 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
